// File: rtl/wb_master_pkg.sv
// Package for the Wishbone master sequencer.
// Holds the FSM state type and the default widths / timeout length shared by
// the interface, the sequencer top and the optional phase timer.
package wb_master_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int TO_CYC_DEF = 1024;

  // IDLE    : waiting for a host command
  // WDATA   : waiting for the host to supply the next write beat
  // REQ     : strobe asserted, waiting for ack to rise
  // RELEASE : strobe dropped, waiting for ack to fall
  // DONE    : command finished, done pulse is generated on exit
  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    REQ,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/wb_master_seq_if.sv
// Wishbone bus bundle between the sequencer (master) and the slave fabric.
// Ports (master view):
//   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o : driven by master
//   wbm_dat_i, wbm_ack_i, wbm_int_i                      : driven by slave
interface wb_master_seq_if
  import wb_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_int_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_int_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_int_i
  );

endinterface

// File: rtl/wb_master_timer.sv
// Per-phase timeout counter for the Wishbone sequencer.
// Ports:
//   clk, rst (sync, active-low) : clock / reset
//   clear                       : restart counting from zero
//   enable                      : count this cycle
//   expired                     : enable is high and TO_CYC cycles have elapsed
//                                 in the current phase (including this one)
module wb_master_timer
  import wb_master_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TO_CYC + 1);

  logic [W-1:0] count;

  // Counter saturates once expired so it never wraps back to a live value.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == W'(TO_CYC - 1));

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone master sequencer: turns one host command (address, beat count,
// direction) into a run of single-beat four-phase Wishbone accesses at
// incrementing addresses. cyc is held across all beats of one command.
// Optional feature macro: WB_MASTER_TIMEOUT_EN adds a per-phase timeout that
// aborts the command with err pulsed alongside done.
// Ports:
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready/cmd_we/cmd_adr/cmd_cnt : host command channel
//   wr_valid/wr_ready/wr_dat                   : write beat data from host
//   rd_valid/rd_dat                            : read beat data to host
//   done, err                                  : end-of-command pulses
//   int_o                                      : slave interrupt, registered
//   wb                                         : Wishbone master bus
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_dat,
  output logic              done,
  output logic              err,
  output logic              int_o,
  wb_master_seq_if.master   wb
);

  state_t            state, state_next;
  logic              we_r, mid_cmd, ack_armed;
  logic              rd_valid_r, done_r, int_r;
  logic [ADDR_W-1:0] adr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] dat_o_r, rd_dat_r;
  logic              accept, wr_take, ack_take, ack_gone, timed_out, abort;

  // Ready strobes are gated by reset so nothing is offered while rst is low.
  assign cmd_ready = rst && (state == IDLE);
  assign wr_ready  = rst && (state == WDATA);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_take   = wr_valid && wr_ready;

  // An ack that was already high when REQ was entered is stale and is
  // ignored until ack has been observed low at least once.
  assign ack_take  = (state == REQ) && wb.wbm_ack_i && ack_armed;
  assign ack_gone  = (state == RELEASE) && !wb.wbm_ack_i;
  assign abort     = timed_out && !ack_take && !ack_gone &&
                     ((state == REQ) || (state == RELEASE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a real handshake edge wins over a coincident timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_cnt == '0)  state_next = DONE;
          else if (cmd_we)    state_next = WDATA;
          else                state_next = REQ;
        end
      end
      WDATA:   if (wr_take) state_next = REQ;
      REQ: begin
        if (ack_take)       state_next = RELEASE;
        else if (abort)     state_next = DONE;
      end
      RELEASE: begin
        if (ack_gone) begin
          if (cnt_r == CNT_W'(1)) state_next = DONE;
          else if (we_r)          state_next = WDATA;
          else                    state_next = REQ;
        end else if (abort) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command latches, beat/address counters, read capture and pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_r       <= 1'b0;
      mid_cmd    <= 1'b0;
      ack_armed  <= 1'b0;
      adr_r      <= '0;
      cnt_r      <= '0;
      dat_o_r    <= '0;
      rd_dat_r   <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      int_r      <= 1'b0;
    end else begin
      rd_valid_r <= ack_take && !we_r;
      done_r     <= (state == DONE);
      int_r      <= wb.wbm_int_i;
      if (accept) begin
        we_r    <= cmd_we;
        adr_r   <= cmd_adr;
        cnt_r   <= cmd_cnt;
        mid_cmd <= 1'b0;
      end
      if (wr_take) dat_o_r <= wr_dat;
      if (ack_take && !we_r) rd_dat_r <= wb.wbm_dat_i;
      if (ack_gone) begin
        cnt_r   <= cnt_r - CNT_W'(1);
        adr_r   <= adr_r + ADDR_W'(1);
        mid_cmd <= 1'b1;
      end
      if (state == DONE) mid_cmd <= 1'b0;
      if ((state_next == REQ) && (state != REQ)) begin
        ack_armed <= !wb.wbm_ack_i;
      end else if ((state == REQ) && !wb.wbm_ack_i) begin
        ack_armed <= 1'b1;
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  logic in_phase, err_pend, err_r;

  assign in_phase = (state == REQ) || (state == RELEASE);

  // Timer restarts on every state change, so each phase gets its own budget.
  wb_master_timer #(.TO_CYC(TO_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_next != state),
    .enable  (in_phase),
    .expired (timed_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_pend <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (accept)     err_pend <= 1'b0;
      else if (abort) err_pend <= 1'b1;
      err_r <= (state == DONE) && err_pend;
    end
  end

  assign err = err_r;
`else
  logic unused_to;
  assign unused_to = (TO_CYC == 0);
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  assign wb.wbm_cyc_o = (state == REQ) || (state == RELEASE) ||
                        ((state == WDATA) && mid_cmd);
  assign wb.wbm_stb_o = (state == REQ);
  assign wb.wbm_we_o  = we_r;
  assign wb.wbm_adr_o = adr_r;
  assign wb.wbm_dat_o = dat_o_r;
  assign rd_valid     = rd_valid_r;
  assign rd_dat       = rd_dat_r;
  assign done         = done_r;
  assign int_o        = int_r;

endmodule
